// File: rtl/leds_decoder.sv
// leds_decoder
// Recovers the counter value, direction and step events of a bidirectional
// thermometer-style LED bar generator from its literal 4-bit bus.
//
// Ports:
//   clk_i      : single clock, all state changes on its rising edge
//   rst_i      : asynchronous active-high reset
//   enable_i   : sample strobe, leds_ni is evaluated only when high
//   leds_ni    : LED bar bus, taken literally
//   locked_o   : high while a valid sequence is being tracked
//   dir_o      : recovered direction (0 = right-shift, 1 = left-shift)
//   phase_o    : recovered generator counter value 0..7
//   step_o     : one-cycle pulse per accepted step while locked
//   wrap_o     : one-cycle pulse when phase_o goes 7 -> 0
//   err_o      : one-cycle pulse per detected sequence error
//   err_cnt_o  : saturating error count
module leds_decoder #(
  parameter int unsigned LOCK_STEPS = 2,
  parameter int unsigned ERR_W      = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic [3:0]       leds_ni,
  output logic             locked_o,
  output logic             dir_o,
  output logic [2:0]       phase_o,
  output logic             step_o,
  output logic             wrap_o,
  output logic             err_o,
  output logic [ERR_W-1:0] err_cnt_o
);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  localparam logic [2:0]       LOCK_STEPS_C = 3'(LOCK_STEPS);
  localparam logic [ERR_W-1:0] ERR_MAX_C    = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_ONE_C    = {{(ERR_W-1){1'b0}}, 1'b1};

  // Bar pattern to index; bit 3 of the result flags a legal pattern.
  function automatic logic [3:0] decode_idx(input logic [3:0] leds);
    logic [3:0] res;
    case (leds)
      4'b1111: res = {1'b1, 3'd0};
      4'b0111: res = {1'b1, 3'd1};
      4'b0011: res = {1'b1, 3'd2};
      4'b0001: res = {1'b1, 3'd3};
      4'b0000: res = {1'b1, 3'd4};
      4'b1000: res = {1'b1, 3'd5};
      4'b1100: res = {1'b1, 3'd6};
      4'b1110: res = {1'b1, 3'd7};
      default: res = {1'b0, 3'd0};
    endcase
    return res;
  endfunction

  // Direction 1 counts the index downwards, so its phase is the negated index.
  function automatic logic [2:0] phase_of(input logic [2:0] k, input logic dir);
    logic [2:0] p;
    if (dir) begin
      p = 3'd0 - k;
    end else begin
      p = k;
    end
    return p;
  endfunction

  state_t           state_r, state_s;
  logic [2:0]       b_r, b_s;
  logic [2:0]       cnt_r, cnt_s;
  logic             cand_r, cand_s;
  logic             dir_r, dir_s;
  logic [2:0]       phase_r, phase_s;
  logic             locked_r, locked_s;
  logic             step_r, step_s;
  logic             wrap_r, wrap_s;
  logic             err_r, err_s;
  logic [ERR_W-1:0] err_cnt_r, err_cnt_s;

  logic [3:0]       dec_s;
  logic             valid_s;
  logic [2:0]       k_s;
  logic             stall_s, up_s, down_s;
  logic [2:0]       cnt_nxt_s;

  // Sample classification and next-state / next-output computation.
  always_comb begin
    dec_s     = decode_idx(leds_ni);
    valid_s   = dec_s[3];
    k_s       = dec_s[2:0];
    stall_s   = (k_s == b_r);
    up_s      = (k_s == (b_r + 3'd1));
    down_s    = (k_s == (b_r - 3'd1));
    cnt_nxt_s = 3'd0;

    state_s   = state_r;
    b_s       = b_r;
    cnt_s     = cnt_r;
    cand_s    = cand_r;
    dir_s     = dir_r;
    phase_s   = phase_r;
    step_s    = 1'b0;
    wrap_s    = 1'b0;
    err_s     = 1'b0;

    if (enable_i) begin
      case (state_r)
        ST_UNLOCKED: begin
          if (valid_s) begin
            state_s = ST_ACQUIRE;
            b_s     = k_s;
            cnt_s   = 3'd0;
          end else begin
            state_s = ST_UNLOCKED;
          end
        end
        ST_ACQUIRE: begin
          if (!valid_s) begin
            state_s = ST_UNLOCKED;
          end else if (stall_s) begin
            state_s = ST_ACQUIRE;
          end else if (up_s || down_s) begin
            b_s    = k_s;
            cand_s = down_s;
            // A count of zero means no previous step to continue from.
            if ((cnt_r != 3'd0) && (cand_r == down_s)) begin
              cnt_nxt_s = cnt_r + 3'd1;
            end else begin
              cnt_nxt_s = 3'd1;
            end
            if (cnt_nxt_s == LOCK_STEPS_C) begin
              state_s = ST_LOCKED;
              dir_s   = down_s;
              phase_s = phase_of(k_s, down_s);
              cnt_s   = 3'd0;
            end else begin
              cnt_s   = cnt_nxt_s;
            end
          end else begin
            b_s   = k_s;
            cnt_s = 3'd0;
          end
        end
        ST_LOCKED: begin
          if (!valid_s) begin
            err_s   = 1'b1;
            state_s = ST_UNLOCKED;
          end else if (stall_s) begin
            state_s = ST_LOCKED;
          end else if ((up_s && !dir_r) || (down_s && dir_r)) begin
            b_s     = k_s;
            phase_s = phase_r + 3'd1;
            step_s  = 1'b1;
            wrap_s  = (phase_r == 3'd7);
          end else begin
            err_s   = 1'b1;
            state_s = ST_ACQUIRE;
            b_s     = k_s;
            cnt_s   = 3'd0;
          end
        end
        default: begin
          state_s = ST_UNLOCKED;
        end
      endcase
    end else begin
      state_s = state_r;
    end

    locked_s = (state_s == ST_LOCKED);

    if (err_s && (err_cnt_r != ERR_MAX_C)) begin
      err_cnt_s = err_cnt_r + ERR_ONE_C;
    end else begin
      err_cnt_s = err_cnt_r;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r   <= ST_UNLOCKED;
      b_r       <= 3'd0;
      cnt_r     <= 3'd0;
      cand_r    <= 1'b0;
      dir_r     <= 1'b0;
      phase_r   <= 3'd0;
      locked_r  <= 1'b0;
      step_r    <= 1'b0;
      wrap_r    <= 1'b0;
      err_r     <= 1'b0;
      err_cnt_r <= {ERR_W{1'b0}};
    end else begin
      state_r   <= state_s;
      b_r       <= b_s;
      cnt_r     <= cnt_s;
      cand_r    <= cand_s;
      dir_r     <= dir_s;
      phase_r   <= phase_s;
      locked_r  <= locked_s;
      step_r    <= step_s;
      wrap_r    <= wrap_s;
      err_r     <= err_s;
      err_cnt_r <= err_cnt_s;
    end
  end

  assign locked_o  = locked_r;
  assign dir_o     = dir_r;
  assign phase_o   = phase_r;
  assign step_o    = step_r;
  assign wrap_o    = wrap_r;
  assign err_o     = err_r;
  assign err_cnt_o = err_cnt_r;

endmodule

// File: tb/tb_leds_decoder.sv
// Self-checking bench for leds_decoder: a queue-based behavioural model is
// compared against the DUT on every falling edge, plus literal spot checks.
module tb_leds_decoder;

  localparam int LOCK_STEPS = 2;
  localparam int ERR_W      = 8;
  localparam int ERR_MAX    = (1 << ERR_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b0;
  logic [3:0]       leds = 4'b0000;
  logic             locked_o, dir_o, step_o, wrap_o, err_o;
  logic [2:0]       phase_o;
  logic [ERR_W-1:0] err_cnt_o;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  leds_decoder #(.LOCK_STEPS(LOCK_STEPS), .ERR_W(ERR_W)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .leds_ni(leds),
    .locked_o(locked_o), .dir_o(dir_o), .phase_o(phase_o), .step_o(step_o),
    .wrap_o(wrap_o), .err_o(err_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int m_state = 0;   // 0 unlocked, 1 acquiring, 2 locked
  int m_b = 0;
  int m_dir = 0, m_phase = 0, m_cnt = 0;
  int m_locked = 0, m_step = 0, m_wrap = 0, m_err = 0;
  int run_q[$];      // directions of the current trailing run of steps

  function automatic int bar_index(input logic [3:0] v);
    logic [3:0] tbl [8];
    tbl = '{4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000, 4'b1000, 4'b1100, 4'b1110};
    for (int i = 0; i < 8; i++) if (tbl[i] == v) return i;
    return -1;
  endfunction

  task automatic model_error();
    m_err = 1;
    if (m_cnt < ERR_MAX) m_cnt = m_cnt + 1;
  endtask

  initial begin
    int k, d, sd;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_state = 0; m_b = 0; m_dir = 0; m_phase = 0; m_cnt = 0;
        m_step = 0; m_wrap = 0; m_err = 0; run_q.delete();
      end else begin
        m_step = 0; m_wrap = 0; m_err = 0;
        if (enable) begin
          k = bar_index(leds);
          d = (k - m_b + 8) % 8;   // 1: index up (dir 0), 7: index down (dir 1)
          sd = (d == 7) ? 1 : 0;
          if (m_state == 0) begin
            if (k >= 0) begin m_state = 1; m_b = k; run_q.delete(); end
          end else if (m_state == 1) begin
            if (k < 0) m_state = 0;
            else if (d == 1 || d == 7) begin
              m_b = k;
              if (run_q.size() > 0 && run_q[$] != sd) run_q.delete();
              run_q.push_back(sd);
              if (run_q.size() >= LOCK_STEPS) begin
                m_state = 2; m_dir = sd;
                m_phase = sd ? (8 - k) % 8 : k;
                run_q.delete();
              end
            end else if (d != 0) begin
              m_b = k; run_q.delete();
            end
          end else begin
            if (k < 0) begin model_error(); m_state = 0; end
            else if ((d == 1 && m_dir == 0) || (d == 7 && m_dir == 1)) begin
              m_b = k;
              m_phase = (m_phase + 1) % 8;
              m_step = 1;
              m_wrap = (m_phase == 0);
            end else if (d != 0) begin
              model_error(); m_state = 1; m_b = k; run_q.delete();
            end
          end
        end
      end
      m_locked = (m_state == 2);
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("locked_o", int'(locked_o), m_locked);
        chk("dir_o", int'(dir_o), m_dir);
        chk("phase_o", int'(phase_o), m_phase);
        chk("step_o", int'(step_o), m_step);
        chk("wrap_o", int'(wrap_o), m_wrap);
        chk("err_o", int'(err_o), m_err);
        chk("err_cnt_o", int'(err_cnt_o), m_cnt);
      end
    end
  end

  task automatic drive(input logic [3:0] v);
    leds = v;
    enable = 1'b1;
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    chk("reset locked", int'(locked_o), 0);
    chk("reset phase", int'(phase_o), 0);
    chk("reset err_cnt", int'(err_cnt_o), 0);
    cmp_en = 1'b1;

    // Direction-0 lock and first step
    drive(4'b1111); drive(4'b0111); drive(4'b0011);
    chk("dir0 locked", int'(locked_o), 1);
    chk("dir0 dir", int'(dir_o), 0);
    chk("dir0 phase", int'(phase_o), 2);
    drive(4'b0001);
    chk("dir0 step", int'(step_o), 1);
    chk("dir0 phase3", int'(phase_o), 3);

    // Stalls then jump, reacquire
    drive(4'b0001); drive(4'b0001); drive(4'b0001);
    chk("stall step", int'(step_o), 0);
    chk("stall err", int'(err_o), 0);
    drive(4'b1100);
    chk("jump err", int'(err_o), 1);
    chk("jump unlocked", int'(locked_o), 0);
    chk("jump err_cnt", int'(err_cnt_o), 1);
    drive(4'b1110); drive(4'b1111);
    chk("jump relock", int'(locked_o), 1);
    chk("jump relock phase", int'(phase_o), 0);
    chk("jump relock dir", int'(dir_o), 0);

    // Invalid pattern while locked
    drive(4'b0111); drive(4'b0011); drive(4'b0001);
    drive(4'b0101);
    chk("invalid err", int'(err_o), 1);
    chk("invalid err_cnt", int'(err_cnt_o), 2);
    chk("invalid unlocked", int'(locked_o), 0);
    drive(4'b0001);
    chk("invalid err one cycle", int'(err_o), 0);
    drive(4'b0000); drive(4'b1000);
    chk("invalid relock", int'(locked_o), 1);
    chk("invalid relock phase", int'(phase_o), 5);

    // Direction 1 up to phase 6, then asynchronous reset mid-cycle
    pulse_reset();
    drive(4'b1111); drive(4'b1110); drive(4'b1100);
    chk("dir1 locked", int'(locked_o), 1);
    chk("dir1 dir", int'(dir_o), 1);
    chk("dir1 phase", int'(phase_o), 2);
    drive(4'b1000); drive(4'b0000); drive(4'b0001); drive(4'b0011);
    chk("dir1 phase6", int'(phase_o), 6);
    #1 rst = 1'b1;
    #1;
    chk("async locked", int'(locked_o), 0);
    chk("async dir", int'(dir_o), 0);
    chk("async phase", int'(phase_o), 0);
    chk("async step", int'(step_o), 0);
    chk("async wrap", int'(wrap_o), 0);
    chk("async err", int'(err_o), 0);
    chk("async err_cnt", int'(err_cnt_o), 0);
    @(posedge clk);
    #2 rst = 1'b0;

    // Direction 1 full revolution with wrap
    drive(4'b1111); drive(4'b1110); drive(4'b1100);
    drive(4'b1000); drive(4'b0000); drive(4'b0001); drive(4'b0011);
    drive(4'b0111);
    chk("wrap phase7", int'(phase_o), 7);
    chk("wrap not yet", int'(wrap_o), 0);
    drive(4'b1111);
    chk("wrap phase0", int'(phase_o), 0);
    chk("wrap pulse", int'(wrap_o), 1);

    // Enable gating with random bus values
    for (int i = 0; i < 10; i++) begin
      leds = 4'($urandom_range(0, 15));
      enable = 1'b0;
      @(posedge clk);
      #2;
    end
    chk("gated locked", int'(locked_o), 1);
    chk("gated dir", int'(dir_o), 1);
    chk("gated phase", int'(phase_o), 0);
    chk("gated wrap", int'(wrap_o), 0);

    // Error counter saturation
    for (int i = 0; i < 300; i++) begin
      drive(4'b1111); drive(4'b0111); drive(4'b0011); drive(4'b0101);
    end
    chk("saturated err_cnt", int'(err_cnt_o), 255);

    enable = 1'b0;
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
